inv_bank: RTL and testbench

- Parameterised bit-wise inverter with a purely combinational data path: Y = ~A.
- Adds a clocked monitor path: registered copy of the output, a saturating toggle counter and an optional self-check flag.
- Used as a leaf primitive wherever an inverted copy of a bus is needed alongside activity statistics.

---
 rtl/inv_pkg.sv | 20 ++
 rtl/inv_toggle_cnt.sv | 32 +++
 rtl/inv_bank.sv | 76 +++++++
 tb/tb_inv_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_pkg.sv
// Shared constants and helpers for the inv_bank inverter and its toggle monitor.
package inv_pkg;

   localparam int unsigned DefaultWidth = 1;
   localparam int unsigned DefaultCntW  = 16;
   localparam int unsigned MaxCntW      = 64;

   // Y_q resets to the inverse of an all-zero A.
   localparam logic YqRstBit = 1'b1;

   function automatic logic [MaxCntW-1:0] cnt_all_ones(input int unsigned w);
      logic [MaxCntW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MaxCntW; i++) begin
         if (i < w) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/inv_toggle_cnt.sv
// Saturating event counter: increments once per cycle with chg high, holds at all-ones.
module inv_toggle_cnt
   import inv_pkg::*;
#(
   parameter int unsigned CNT_W = DefaultCntW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chg,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_all_ones(CNT_W));

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (chg && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
   assign sat = &cnt_q;

endmodule

// File: rtl/inv_bank.sv
// Combinational bus inverter with registered copy, toggle statistics and a sticky self-check.
// Define INV_SELFCHECK_EN to enable the A_q shadow register and the err flag.
module inv_bank
   import inv_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned CNT_W = DefaultCntW
) (
   input  logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] Y,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] Y_q,
   output logic [CNT_W-1:0] tog_cnt,
   output logic             tog_sat,
   output logic             err
);

   logic [WIDTH-1:0] y_d;
   logic [WIDTH-1:0] yq_q;
   logic             chg;

   assign y_d = ~A;
   assign Y   = y_d;

   always_ff @(posedge clk) begin
      if (rst) yq_q <= {WIDTH{YqRstBit}};
      else     yq_q <= y_d;
   end

   assign Y_q = yq_q;

   // Any bit differing between the incoming and held value counts as a single event.
   assign chg = (y_d != yq_q);

   inv_toggle_cnt #(
      .CNT_W (CNT_W)
   ) u_toggle_cnt (
      .clk (clk),
      .rst (rst),
      .chg (chg),
      .cnt (tog_cnt),
      .sat (tog_sat)
   );

`ifdef INV_SELFCHECK_EN
   logic [WIDTH-1:0] a_q;
   logic             err_q;
   logic             err_d;
   logic             x_err;

   // $isunknown folds to 0 in two-state hardware, so this term costs nothing in synthesis.
   assign x_err = !$isunknown(A) && $isunknown(Y);

   always_comb begin
      err_d = err_q;
      if ((yq_q != ~a_q) || x_err) err_d = 1'b1;
   end

   // a_q resets to zero so ~a_q matches the all-ones Y_q reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         err_q <= 1'b0;
      end else begin
         a_q   <= A;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_bank.sv
// Directed self-checking bench for inv_bank: three instances cover WIDTH=1, CNT_W=3 and WIDTH=8.
module tb_inv_bank;

   logic        clk = 1'b0;
   logic        clk_run = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        rst1, rst3, rst8;
   logic        a1, a3;
   logic [7:0]  a8;
   logic        y1, yq1, sat1, err1;
   logic        y3, yq3, sat3, err3;
   logic [7:0]  y8, yq8;
   logic        sat8, err8;
   logic [15:0] cnt1, cnt8;
   logic [2:0]  cnt3;

   always #5 if (clk_run) clk = ~clk;

   inv_bank #(.WIDTH(1), .CNT_W(16)) u_w1 (
      .A(a1), .Y(y1), .clk(clk), .rst(rst1), .Y_q(yq1),
      .tog_cnt(cnt1), .tog_sat(sat1), .err(err1)
   );

   inv_bank #(.WIDTH(1), .CNT_W(3)) u_c3 (
      .A(a3), .Y(y3), .clk(clk), .rst(rst3), .Y_q(yq3),
      .tog_cnt(cnt3), .tog_sat(sat3), .err(err3)
   );

   inv_bank #(.WIDTH(8), .CNT_W(16)) u_w8 (
      .A(a8), .Y(y8), .clk(clk), .rst(rst8), .Y_q(yq8),
      .tog_cnt(cnt8), .tog_sat(sat8), .err(err8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_comb();
      a1 = 1'b0;
      #10;
      n_cmp++;
      if (y1 !== 1'b1) begin
         n_bad++; $display("FAIL comb_a0: Y=%b want 1", y1);
      end
      a1 = 1'b1;
      #10;
      n_cmp++;
      if (y1 !== 1'b0) begin
         n_bad++; $display("FAIL comb_a1: Y=%b want 0", y1);
      end
   endtask

   task automatic test_reset();
      a1 = 1'b0; rst1 = 1'b1;
      tick(); tick();
      n_cmp++;
      if (yq1 !== 1'b1 || cnt1 !== 16'd0 || err1 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: Y_q=%b cnt=%0d err=%b want 1/0/0", yq1, cnt1, err1);
      end
      rst1 = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (cnt1 !== 16'd0 || yq1 !== 1'b1) begin
         n_bad++; $display("FAIL hold_zero: cnt=%0d Y_q=%b want 0/1", cnt1, yq1);
      end
   endtask

   task automatic test_toggle();
      for (int i = 0; i < 5; i++) begin
         a1 = ~a1;
         #1;
         n_cmp++;
         if (yq1 !== a1) begin
            n_bad++; $display("FAIL toggle_lag[%0d]: Y_q=%b want %b", i, yq1, a1);
         end
         tick();
         n_cmp++;
         if (yq1 !== ~a1) begin
            n_bad++; $display("FAIL toggle_follow[%0d]: Y_q=%b want %b", i, yq1, ~a1);
         end
      end
      n_cmp++;
      if (cnt1 !== 16'd5) begin
         n_bad++; $display("FAIL toggle_cnt: cnt=%0d want 5", cnt1);
      end
   endtask

   task automatic test_saturate();
      a3 = 1'b0; rst3 = 1'b1;
      tick();
      rst3 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         a3 = ~a3;
         tick();
         if (i == 5) begin
            n_cmp++;
            if (cnt3 !== 3'd6 || sat3 !== 1'b0) begin
               n_bad++; $display("FAIL sat_pre: cnt=%0d sat=%b want 6/0", cnt3, sat3);
            end
         end
      end
      n_cmp++;
      if (cnt3 !== 3'd7 || sat3 !== 1'b1) begin
         n_bad++; $display("FAIL sat_hold: cnt=%0d sat=%b want 7/1", cnt3, sat3);
      end
      a3 = ~a3; rst3 = 1'b1;
      tick();
      n_cmp++;
      if (cnt3 !== 3'd0 || sat3 !== 1'b0 || yq3 !== 1'b1 || err3 !== 1'b0) begin
         n_bad++;
         $display("FAIL sat_midrst: cnt=%0d sat=%b Y_q=%b err=%b want 0/0/1/0",
                  cnt3, sat3, yq3, err3);
      end
      rst3 = 1'b0;
   endtask

   task automatic test_width8();
      a8 = 8'h00; rst8 = 1'b1;
      tick();
      rst8 = 1'b0;
      a8 = 8'hA5;
      #1;
      n_cmp++;
      if (y8 !== 8'h5A) begin
         n_bad++; $display("FAIL w8_comb: Y=%h want 5a", y8);
      end
      tick();
      n_cmp++;
      if (yq8 !== 8'h5A || cnt8 !== 16'd1) begin
         n_bad++; $display("FAIL w8_reg: Y_q=%h cnt=%0d want 5a/1", yq8, cnt8);
      end
      a8 = 8'h5A;
      #1;
      n_cmp++;
      if (y8 !== 8'hA5) begin
         n_bad++; $display("FAIL w8_comb2: Y=%h want a5", y8);
      end
      tick();
      n_cmp++;
      if (yq8 !== 8'hA5 || cnt8 !== 16'd2) begin
         n_bad++; $display("FAIL w8_multibit: Y_q=%h cnt=%0d want a5/2", yq8, cnt8);
      end
      repeat (2) tick();
      n_cmp++;
      if (cnt8 !== 16'd2 || err8 !== 1'b0) begin
         n_bad++; $display("FAIL w8_steady: cnt=%0d err=%b want 2/0", cnt8, err8);
      end
   endtask

   task automatic test_selfcheck();
      a1 = 1'b0; rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         a1 = ~a1;
         tick();
      end
      n_cmp++;
      if (err1 !== 1'b0 || cnt1 !== 16'd20) begin
         n_bad++; $display("FAIL sc_clean: err=%b cnt=%0d want 0/20", err1, cnt1);
      end
`ifdef INV_SELFCHECK_EN
      force u_w1.yq_q = a1;
      tick();
      release u_w1.yq_q;
      tick();
      n_cmp++;
      if (err1 !== 1'b1) begin
         n_bad++; $display("FAIL sc_detect: err=%b want 1", err1);
      end
      repeat (3) begin
         a1 = ~a1;
         tick();
      end
      n_cmp++;
      if (err1 !== 1'b1) begin
         n_bad++; $display("FAIL sc_sticky: err=%b want 1", err1);
      end
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      n_cmp++;
      if (err1 !== 1'b0) begin
         n_bad++; $display("FAIL sc_clear: err=%b want 0", err1);
      end
`else
      repeat (3) begin
         a1 = ~a1;
         tick();
      end
      n_cmp++;
      if (err1 !== 1'b0) begin
         n_bad++; $display("FAIL sc_tied: err=%b want 0", err1);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst1 = 1'b1; rst3 = 1'b1; rst8 = 1'b1;
      a1 = 1'b0; a3 = 1'b0; a8 = 8'h00;
      test_comb();
      clk_run = 1'b1;
      test_reset();
      test_toggle();
      test_saturate();
      test_width8();
      test_selfcheck();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
